// File: rtl/action_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : action_scheduler_pkg
// Description : Shared encodings for the action scheduler: action codes,
//               player IDs, FSM states and the button priority encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package action_scheduler_pkg;

    // Action codes carried on CMD_ACTION
    localparam logic [1:0] ACT_LEFT  = 2'd0;
    localparam logic [1:0] ACT_RIGHT = 2'd1;
    localparam logic [1:0] ACT_PUNCH = 2'd2;
    localparam logic [1:0] ACT_KICK  = 2'd3;

    // Player IDs carried on CMD_PLAYER
    localparam logic PLAYER_1 = 1'b0;
    localparam logic PLAYER_2 = 1'b1;

    // Arbiter FSM states
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } sched_state_t;

    // Highest button index wins when several pulses arrive together.
    function automatic logic [1:0] prio_encode(input logic [3:0] act);
        logic [1:0] code;
        if (act[3])      code = ACT_KICK;
        else if (act[2]) code = ACT_PUNCH;
        else if (act[1]) code = ACT_RIGHT;
        else             code = ACT_LEFT;
        return code;
    endfunction

    function automatic logic is_attack(input logic [1:0] action);
        return (action == ACT_PUNCH) || (action == ACT_KICK);
    endfunction

endpackage
`default_nettype wire

// File: rtl/action_scheduler_slot.sv
`default_nettype none
// ============================================================================
// Module      : player_action_slot
// Description : Per-player front end. Priority-encodes the button pulses,
//               holds one pending action (latest wins), runs the attack
//               cooldown counter and generates the BUSY / DROP flags.
// Ports       : clk, rst_n           - clock, async active-low reset
//               i_en                 - round active; low flushes pending
//               i_act[3:0]           - debounced pulses (left,right,punch,kick)
//               i_clear              - arbiter took the pending action
//               i_load_cooldown      - an attack of this player was accepted
//               i_discard_attack     - handshake of this player's command
//               o_pend_valid/action  - pending action
//               o_busy               - cooldown counter nonzero (registered)
//               o_drop               - one-cycle discard pulse
// Revision    : 1.0 - initial release
// ============================================================================
module player_action_slot
    import action_scheduler_pkg::*;
#(
    parameter int unsigned     CD_W     = 20,
    parameter logic [CD_W-1:0] COOLDOWN = 20'd1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic [3:0] i_act,
    input  logic       i_clear,
    input  logic       i_load_cooldown,
    input  logic       i_discard_attack,
    output logic       o_pend_valid,
    output logic [1:0] o_pend_action,
    output logic       o_busy,
    output logic       o_drop
);

    localparam logic [CD_W-1:0] C_CD_ONE = CD_W'(1);

    logic            r_pend_valid;
    logic [1:0]      r_pend_action;
    logic [CD_W-1:0] r_cd;
    logic            r_busy;
    logic            r_drop;

    logic [CD_W-1:0] w_cd_next;
    logic [1:0]      w_new_action;
    logic            w_any;
    logic            w_reject;
    logic            w_capture;
    logic            w_pend_attack;
    logic            w_discard_hit;

    assign w_any         = i_en & (|i_act);
    assign w_new_action  = prio_encode(i_act);
    // An attack arriving while the counter still runs is thrown away.
    assign w_reject      = w_any & is_attack(w_new_action) & (r_cd != '0);
    assign w_capture     = w_any & ~w_reject;
    assign w_pend_attack = r_pend_valid & is_attack(r_pend_action);
    // A queued attack behind an accepted command of the same player would
    // land inside the new animation, so it is discarded at the handshake.
    assign w_discard_hit = i_en & i_discard_attack & w_pend_attack;

    always_comb begin
        w_cd_next = r_cd;
        if (i_load_cooldown) begin
            w_cd_next = COOLDOWN;
        end else if (r_cd != '0) begin
            w_cd_next = r_cd - C_CD_ONE;
        end
    end

    // Capture is checked before clear/discard so that a pulse in the same
    // cycle as the arbiter taking the old action is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_valid  <= 1'b0;
            r_pend_action <= ACT_LEFT;
        end else if (!i_en) begin
            r_pend_valid  <= 1'b0;
        end else if (w_capture) begin
            r_pend_valid  <= 1'b1;
            r_pend_action <= w_new_action;
        end else if (i_clear || w_discard_hit) begin
            r_pend_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cd   <= '0;
            r_busy <= 1'b0;
            r_drop <= 1'b0;
        end else begin
            r_cd   <= w_cd_next;
            r_busy <= (w_cd_next != '0);
            r_drop <= w_reject | w_discard_hit;
        end
    end

    assign o_pend_valid  = r_pend_valid;
    assign o_pend_action = r_pend_action;
    assign o_busy        = r_busy;
    assign o_drop        = r_drop;

endmodule
`default_nettype wire

// File: rtl/action_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : action_scheduler
// Description : Collects action pulses from two players, keeps one pending
//               action each and offers them round-robin on a single
//               valid/ready command port, with per-player attack cooldown.
// Ports       : CLK, RESET_N             - clock, async active-low reset
//               EN                       - round active
//               P1_ACT, P2_ACT [3:0]     - debounced pulses per player
//               CMD_READY                - engine accepts command
//               CMD_VALID/PLAYER/ACTION  - command output register
//               P1_BUSY, P2_BUSY         - cooldown running
//               P1_DROP, P2_DROP         - action discarded pulse
// Revision    : 1.0 - initial release
// ============================================================================
module action_scheduler
    import action_scheduler_pkg::*;
#(
    parameter int unsigned     CD_W     = 20,
    parameter logic [CD_W-1:0] COOLDOWN = 20'd1000000
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       EN,
    input  logic [3:0] P1_ACT,
    input  logic [3:0] P2_ACT,
    input  logic       CMD_READY,
    output logic       CMD_VALID,
    output logic       CMD_PLAYER,
    output logic [1:0] CMD_ACTION,
    output logic       P1_BUSY,
    output logic       P2_BUSY,
    output logic       P1_DROP,
    output logic       P2_DROP
);

    sched_state_t r_state;
    sched_state_t w_state_next;

    logic       r_cmd_valid;
    logic       r_cmd_player;
    logic [1:0] r_cmd_action;
    logic       r_last_grant;

    logic [3:0] w_act         [2];
    logic [1:0] w_pend_action [2];
    logic [1:0] w_pend_valid;
    logic [1:0] w_busy;
    logic [1:0] w_drop;
    logic [1:0] w_clear;
    logic [1:0] w_load_cd;
    logic [1:0] w_discard;
    logic       w_sel;
    logic       w_load_cmd;
    logic       w_handshake;

    assign w_act[0] = P1_ACT;
    assign w_act[1] = P2_ACT;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            player_action_slot #(
                .CD_W     (CD_W),
                .COOLDOWN (COOLDOWN)
            ) u_slot (
                .clk              (CLK),
                .rst_n            (RESET_N),
                .i_en             (EN),
                .i_act            (w_act[gi]),
                .i_clear          (w_clear[gi]),
                .i_load_cooldown  (w_load_cd[gi]),
                .i_discard_attack (w_discard[gi]),
                .o_pend_valid     (w_pend_valid[gi]),
                .o_pend_action    (w_pend_action[gi]),
                .o_busy           (w_busy[gi]),
                .o_drop           (w_drop[gi])
            );
        end
    endgenerate

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load_cmd   = 1'b0;
        w_handshake  = 1'b0;
        w_sel        = PLAYER_1;
        w_clear      = 2'b00;
        w_load_cd    = 2'b00;
        w_discard    = 2'b00;
        case (r_state)
            ST_IDLE: begin
                if (EN && (|w_pend_valid)) begin
                    // On a tie the player not served last goes first.
                    if (&w_pend_valid) begin
                        w_sel = ~r_last_grant;
                    end else begin
                        w_sel = w_pend_valid[1];
                    end
                    w_load_cmd     = 1'b1;
                    w_clear[w_sel] = 1'b1;
                    w_state_next   = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (CMD_READY) begin
                    w_handshake              = 1'b1;
                    w_discard[r_cmd_player]  = 1'b1;
                    w_load_cd[r_cmd_player]  = is_attack(r_cmd_action);
                    w_state_next             = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Command register stays frozen through OFFER; only load and
    // handshake touch it.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cmd_valid  <= 1'b0;
            r_cmd_player <= PLAYER_1;
            r_cmd_action <= ACT_LEFT;
            r_last_grant <= PLAYER_2;
        end else if (w_load_cmd) begin
            r_cmd_valid  <= 1'b1;
            r_cmd_player <= w_sel;
            r_cmd_action <= w_pend_action[w_sel];
        end else if (w_handshake) begin
            r_cmd_valid  <= 1'b0;
            r_last_grant <= r_cmd_player;
        end
    end

    assign CMD_VALID  = r_cmd_valid;
    assign CMD_PLAYER = r_cmd_player;
    assign CMD_ACTION = r_cmd_action;
    assign P1_BUSY    = w_busy[0];
    assign P2_BUSY    = w_busy[1];
    assign P1_DROP    = w_drop[0];
    assign P2_DROP    = w_drop[1];

endmodule
`default_nettype wire
